// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read side and the packed-word output handshake for
// fifo_rd_packer. The packer is the master; its environment uses the slave
// modport.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 6,
    parameter int PACK  = 4
);
    localparam int CW = $clog2(PACK + 1);

    logic [DSIZE-1:0]      rdata;
    logic                  rempty;
    logic                  rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [CW-1:0]         out_cnt;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           word_total;

    modport master (
        input  rdata, rempty, flush, out_ready,
        output rinc, out_data, out_cnt, out_valid, word_total
    );

    modport slave (
        output rdata, rempty, flush, out_ready,
        input  rinc, out_data, out_cnt, out_valid, word_total
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops words from a first-word-fall-through FIFO and packs PACK of them into
// one wide output word, lane 0 in the least significant bits. A flush request
// emits a partially filled word, with the unused upper lanes left at zero.
// While a word is held for the downstream, no further FIFO words are popped.
module fifo_rd_packer #(
    parameter int DSIZE = 6,
    parameter int PACK  = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    fifo_rd_packer_if.master bus
);
    localparam int CW = $clog2(PACK + 1);
    localparam int W  = DSIZE * PACK;
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  lane_q, lane_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   word_total_q, word_total_d;
    logic          pop;

    // The pop strobe is combinational so that a word can be taken on every
    // FILL cycle; it is forced low during reset and whenever a word is held.
    assign pop            = (state_q == FILL) && !bus.rempty && !rrst;
    assign bus.rinc       = pop;
    assign bus.out_data   = lane_q;
    assign bus.out_cnt    = cnt_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.word_total = word_total_q;

    // Next-state logic: collect lanes in FILL, present and wait for acceptance in HOLD.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        lcnt_d       = lcnt_q;
        cnt_d        = cnt_q;
        word_total_d = word_total_q;
        case (state_q)
            FILL: begin
                if (pop) begin
                    for (int i = 0; i < PACK; i++) begin
                        if (lcnt_q == CW'(i)) begin
                            lane_d[i*DSIZE +: DSIZE] = bus.rdata;
                        end
                    end
                    lcnt_d = lcnt_q + CW'(1);
                end
                // A flush counts a pop taken in the same cycle, so an empty
                // packer only emits when that pop supplies the first lane.
                if ((pop && (lcnt_q == LAST_LANE)) ||
                    (bus.flush && (pop || (lcnt_q != '0)))) begin
                    state_d = HOLD;
                    cnt_d   = lcnt_d;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d      = FILL;
                    lane_d       = '0;
                    lcnt_d       = '0;
                    cnt_d        = '0;
                    word_total_d = word_total_q + 16'd1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial or held word.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q      <= FILL;
            lane_q       <= '0;
            lcnt_q       <= '0;
            cnt_q        <= '0;
            word_total_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            lcnt_q       <= lcnt_d;
            cnt_q        <= cnt_d;
            word_total_q <= word_total_d;
        end
    end
endmodule
